bus_sequencer: RTL and testbench

- Hardwired control unit that sequences the shared 32-bit datapath bus: one 5-bit bus source select per cycle, plus register load enables, ALU op, and memory strobes.
- Fetches an instruction, decodes it, and executes it as a fixed micro-step sequence, then loops.
- Sits beside the bus source multiplexer, the register file, the ALU and the memory interface.

---
 rtl/bus_sequencer_if.sv | 36 +++
 rtl/bus_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_bus_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_sequencer_if.sv
// Control bundle between the bus sequencer and the datapath it steers:
// instruction/handshake inputs plus every select, load strobe and status output.
interface bus_sequencer_if;
  logic [31:0] ir;
  logic        mem_ready;
  logic [4:0]  bus_sel;
  logic [15:0] reg_in;
  logic        pc_inc;
  logic        mar_in;
  logic        mdr_in;
  logic        mdr_from_mem;
  logic        ir_in;
  logic        y_in;
  logic        z_in;
  logic        hi_in;
  logic        lo_in;
  logic        out_in;
  logic [4:0]  alu_op;
  logic        mem_read;
  logic        mem_write;
  logic        run;
  logic        bus_error;
  logic [3:0]  step;

  modport master (
    input  ir, mem_ready,
    output bus_sel, reg_in, pc_inc, mar_in, mdr_in, mdr_from_mem, ir_in, y_in, z_in,
           hi_in, lo_in, out_in, alu_op, mem_read, mem_write, run, bus_error, step
  );

  modport slave (
    output ir, mem_ready,
    input  bus_sel, reg_in, pc_inc, mar_in, mdr_in, mdr_from_mem, ir_in, y_in, z_in,
           hi_in, lo_in, out_in, alu_op, mem_read, mem_write, run, bus_error, step
  );
endinterface

// File: rtl/bus_sequencer.sv
// Hardwired control unit: fetches, decodes and executes each instruction as a fixed
// sequence of micro-steps, driving one bus source plus load/ALU/memory strobes per step.
module bus_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input logic             clk,
  input logic             rst_n,
  bus_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    T0 = 4'd0, T1 = 4'd1, T2 = 4'd2, T3 = 4'd3,
    T4 = 4'd4, T5 = 4'd5, T6 = 4'd6, T7 = 4'd7,
    HALT = 4'd15
  } state_t;

  localparam logic [4:0] OP_LD = 5'd0, OP_ST = 5'd2, OP_ADD = 5'd3, OP_ROL = 5'd10;
  localparam logic [4:0] OP_ADDI = 5'd12, OP_ORI = 5'd14, OP_MUL = 5'd15, OP_DIV = 5'd16;
  localparam logic [4:0] OP_IN = 5'd22, OP_OUT = 5'd23, OP_MFHI = 5'd24, OP_MFLO = 5'd25;
  localparam logic [4:0] OP_HALT = 5'd27;

  localparam logic [4:0] SEL_HI = 5'd16, SEL_LO = 5'd17, SEL_ZHI = 5'd18, SEL_ZLO = 5'd19;
  localparam logic [4:0] SEL_PC = 5'd20, SEL_MDR = 5'd21, SEL_INPORT = 5'd22;
  localparam logic [4:0] SEL_C = 5'd25, SEL_IDLE = 5'd31;

  localparam logic [8:0] TIMEOUT_LIMIT = 9'(MEM_TIMEOUT);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic        bus_error_q;

  logic [4:0]  opcode;
  logic [3:0]  ra, rb, rc;
  logic [15:0] ra_onehot;
  logic        is_alu, is_imm, is_muldiv, is_mem;
  logic        waiting, timeout;
  logic        unused_ir;

  logic [4:0]  sel, alu_op;
  logic [15:0] reg_in;
  logic        pc_inc, mar_in, mdr_in, mdr_from_mem, ir_in, y_in, z_in;
  logic        hi_in, lo_in, out_in, mem_read, mem_write;

  assign opcode    = bus.ir[31:27];
  assign ra        = bus.ir[26:23];
  assign rb        = bus.ir[22:19];
  assign rc        = bus.ir[18:15];
  assign ra_onehot = 16'd1 << ra;
  // The low immediate bits reach the bus through the C source, never through here.
  assign unused_ir = ^bus.ir[14:0];

  assign is_alu    = (opcode >= OP_ADD) && (opcode <= OP_ROL);
  assign is_imm    = (opcode >= OP_ADDI) && (opcode <= OP_ORI);
  assign is_muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);
  assign is_mem    = (opcode == OP_LD) || (opcode == OP_ST);

  assign waiting = (state == T1) || (state == T6 && opcode == OP_LD) ||
                   (state == T7 && opcode == OP_ST);
  // The cycle that brings the count to the limit still accepts mem_ready.
  assign timeout = (MEM_TIMEOUT != 0) && (({1'b0, wait_cnt} + 9'd1) == TIMEOUT_LIMIT);

  // Step sequencing, wait-cycle counting and the sticky bus error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= T0;
      wait_cnt    <= 8'd0;
      bus_error_q <= 1'b0;
    end else begin
      wait_cnt <= (waiting && !bus.mem_ready) ? wait_cnt + 8'd1 : 8'd0;
      if (waiting && !bus.mem_ready) begin
        if (timeout) begin
          state       <= HALT;
          bus_error_q <= 1'b1;
        end
      end else begin
        case (state)
          T0:      state <= T1;
          T1:      state <= T2;
          T2:      state <= T3;
          T3: begin
            if (is_alu || is_imm || is_muldiv || is_mem) state <= T4;
            else if (opcode == OP_HALT)                  state <= HALT;
            else                                         state <= T0;
          end
          T4:      state <= T5;
          T5:      state <= (is_alu || is_imm) ? T0 : T6;
          T6:      state <= is_muldiv ? T0 : T7;
          T7:      state <= T0;
          HALT:    state <= HALT;
          default: state <= HALT;
        endcase
      end
    end
  end

  // Outputs decode from the current step and opcode; everything idles while in reset.
  always_comb begin
    sel          = SEL_IDLE;
    reg_in       = 16'd0;
    alu_op       = 5'd0;
    pc_inc       = 1'b0;
    mar_in       = 1'b0;
    mdr_in       = 1'b0;
    mdr_from_mem = 1'b0;
    ir_in        = 1'b0;
    y_in         = 1'b0;
    z_in         = 1'b0;
    hi_in        = 1'b0;
    lo_in        = 1'b0;
    out_in       = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    if (rst_n) begin
      case (state)
        T0: begin
          sel    = SEL_PC;
          mar_in = 1'b1;
          pc_inc = 1'b1;
        end
        // mdr_from_mem only steers the MDR input mux, so it is held for the whole wait.
        T1: begin
          mem_read     = 1'b1;
          mdr_from_mem = 1'b1;
          mdr_in       = bus.mem_ready;
        end
        T2: begin
          sel   = SEL_MDR;
          ir_in = 1'b1;
        end
        T3: begin
          if (is_alu || is_imm || is_mem) begin
            sel  = {1'b0, rb};
            y_in = 1'b1;
          end else if (is_muldiv) begin
            sel  = {1'b0, ra};
            y_in = 1'b1;
          end else begin
            case (opcode)
              OP_IN:   begin sel = SEL_INPORT; reg_in = ra_onehot; end
              OP_OUT:  begin sel = {1'b0, ra};  out_in = 1'b1;     end
              OP_MFHI: begin sel = SEL_HI;      reg_in = ra_onehot; end
              OP_MFLO: begin sel = SEL_LO;      reg_in = ra_onehot; end
              default: ;
            endcase
          end
        end
        T4: begin
          z_in = 1'b1;
          if (is_mem) begin
            sel    = SEL_C;
            alu_op = OP_ADD;
          end else if (is_imm) begin
            sel    = SEL_C;
            alu_op = opcode;
          end else if (is_muldiv) begin
            sel    = {1'b0, rb};
            alu_op = opcode;
          end else begin
            sel    = {1'b0, rc};
            alu_op = opcode;
          end
        end
        T5: begin
          sel = SEL_ZLO;
          if (is_mem)         mar_in = 1'b1;
          else if (is_muldiv) lo_in  = 1'b1;
          else                reg_in = ra_onehot;
        end
        T6: begin
          if (is_muldiv) begin
            sel   = SEL_ZHI;
            hi_in = 1'b1;
          end else if (opcode == OP_ST) begin
            sel    = {1'b0, ra};
            mdr_in = 1'b1;
          end else begin
            mem_read     = 1'b1;
            mdr_from_mem = 1'b1;
            mdr_in       = bus.mem_ready;
          end
        end
        T7: begin
          if (opcode == OP_ST) begin
            mem_write = 1'b1;
          end else begin
            sel    = SEL_MDR;
            reg_in = ra_onehot;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.bus_sel      = sel;
  assign bus.reg_in       = reg_in;
  assign bus.pc_inc       = pc_inc;
  assign bus.mar_in       = mar_in;
  assign bus.mdr_in       = mdr_in;
  assign bus.mdr_from_mem = mdr_from_mem;
  assign bus.ir_in        = ir_in;
  assign bus.y_in         = y_in;
  assign bus.z_in         = z_in;
  assign bus.hi_in        = hi_in;
  assign bus.lo_in        = lo_in;
  assign bus.out_in       = out_in;
  assign bus.alu_op       = alu_op;
  assign bus.mem_read     = mem_read;
  assign bus.mem_write    = mem_write;
  assign bus.run          = (state != HALT);
  assign bus.bus_error    = bus_error_q;
  assign bus.step         = state;

endmodule

// File: tb/tb_bus_sequencer.sv
// Bench for bus_sequencer: table vectors, hand-built corner sequences and random
// instructions, all compared cycle by cycle against a trace built from the step tables.
module tb_bus_sequencer;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  bus_sequencer_if bus();

  bus_sequencer #(.MEM_TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  bus_sel;
    logic [15:0] reg_in;
    logic [9:0]  strb;
    logic [4:0]  alu_op;
    logic        mem_read;
    logic        mem_write;
    logic        run;
    logic        bus_error;
    logic [3:0]  step;
  } obs_t;

  typedef struct {
    string       name;
    logic [31:0] ir;
    int          d1;
    int          d2;
    logic [15:0] exp_regs;
    logic [4:0]  exp_alu;
  } vec_t;

  localparam logic [9:0] S_PC = 10'h200, S_MAR = 10'h100, S_MDRIN = 10'h080, S_MDRMEM = 10'h040;
  localparam logic [9:0] S_IR = 10'h020, S_Y = 10'h010, S_Z = 10'h008, S_HI = 10'h004;
  localparam logic [9:0] S_LO = 10'h002, S_OUT = 10'h001;

  obs_t        exp_q[$];
  bit          rdy_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] seen_regs;
  logic [4:0]  seen_alu;

  function automatic obs_t mk(input logic [4:0] bs, input logic [15:0] rg, input logic [9:0] st,
                              input logic [4:0] alu, input logic mr, input logic mw,
                              input logic [3:0] stp);
    obs_t o;
    o.bus_sel   = bs;
    o.reg_in    = rg;
    o.strb      = st;
    o.alu_op    = alu;
    o.mem_read  = mr;
    o.mem_write = mw;
    o.run       = 1'b1;
    o.bus_error = 1'b0;
    o.step      = stp;
    return o;
  endfunction

  function automatic obs_t halted(input logic err);
    obs_t o;
    o = mk(5'd31, 16'd0, 10'd0, 5'd0, 1'b0, 1'b0, 4'd15);
    o.run       = 1'b0;
    o.bus_error = err;
    return o;
  endfunction

  function automatic obs_t capture();
    obs_t o;
    o.bus_sel   = bus.bus_sel;
    o.reg_in    = bus.reg_in;
    o.strb      = {bus.pc_inc, bus.mar_in, bus.mdr_in, bus.mdr_from_mem, bus.ir_in,
                   bus.y_in, bus.z_in, bus.hi_in, bus.lo_in, bus.out_in};
    o.alu_op    = bus.alu_op;
    o.mem_read  = bus.mem_read;
    o.mem_write = bus.mem_write;
    o.run       = bus.run;
    o.bus_error = bus.bus_error;
    o.step      = bus.step;
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("sel=%0d reg=%h strb=%h alu=%0d rd=%b wr=%b run=%b err=%b step=%0d",
                     o.bus_sel, o.reg_in, o.strb, o.alu_op, o.mem_read, o.mem_write,
                     o.run, o.bus_error, o.step);
  endfunction

  task automatic check_output(input string name, input obs_t want);
    obs_t got;
    got = capture();
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %s, want %s", name, fmt(got), fmt(want));
    end
  endtask

  task automatic check_value(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic push(input obs_t o, input bit r);
    exp_q.push_back(o);
    rdy_q.push_back(r);
  endtask

  // Cycles where mem_ready must not matter get a random value.
  task automatic push_r(input obs_t o);
    push(o, $urandom_range(0, 1) == 1);
  endtask

  task automatic halt_tail(input logic err, input int n);
    for (int i = 0; i < n; i++) push_r(halted(err));
  endtask

  // Memory wait: ready arrives after d idle cycles; at most TO cycles are spent waiting.
  task automatic model_wait(input int d, input logic [9:0] sw, input logic [9:0] sr,
                            input logic mr, input logic mw, input logic [3:0] stp,
                            output bit to);
    to = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (k == d) begin
        push(mk(5'd31, 16'd0, sr, 5'd0, mr, mw, stp), 1'b1);
        return;
      end
      push(mk(5'd31, 16'd0, sw, 5'd0, mr, mw, stp), 1'b0);
      if (TO != 0 && k == TO - 1) begin
        to = 1'b1;
        return;
      end
    end
  endtask

  task automatic build_trace(input logic [31:0] ir, input int d1, input int d2,
                             input int halt_len, output bit halts);
    logic [4:0]  op;
    logic [3:0]  ra, rb, rc;
    logic [15:0] oh;
    bit          to;
    op = ir[31:27];
    ra = ir[26:23];
    rb = ir[22:19];
    rc = ir[18:15];
    oh = 16'd1 << ra;
    halts = 1'b0;
    exp_q.delete();
    rdy_q.delete();
    push_r(mk(5'd20, 16'd0, S_PC | S_MAR, 5'd0, 1'b0, 1'b0, 4'd0));
    model_wait(d1, S_MDRMEM, S_MDRIN | S_MDRMEM, 1'b1, 1'b0, 4'd1, to);
    if (to) begin
      halt_tail(1'b1, halt_len);
      halts = 1'b1;
      return;
    end
    push_r(mk(5'd21, 16'd0, S_IR, 5'd0, 1'b0, 1'b0, 4'd2));
    if (op inside {[5'd3:5'd10], [5'd12:5'd14]}) begin
      push_r(mk({1'b0, rb}, 16'd0, S_Y, 5'd0, 1'b0, 1'b0, 4'd3));
      push_r(mk((op inside {[5'd12:5'd14]}) ? 5'd25 : {1'b0, rc}, 16'd0, S_Z, op,
                1'b0, 1'b0, 4'd4));
      push_r(mk(5'd19, oh, 10'd0, 5'd0, 1'b0, 1'b0, 4'd5));
    end else if (op == 5'd15 || op == 5'd16) begin
      push_r(mk({1'b0, ra}, 16'd0, S_Y, 5'd0, 1'b0, 1'b0, 4'd3));
      push_r(mk({1'b0, rb}, 16'd0, S_Z, op, 1'b0, 1'b0, 4'd4));
      push_r(mk(5'd19, 16'd0, S_LO, 5'd0, 1'b0, 1'b0, 4'd5));
      push_r(mk(5'd18, 16'd0, S_HI, 5'd0, 1'b0, 1'b0, 4'd6));
    end else if (op == 5'd0 || op == 5'd2) begin
      push_r(mk({1'b0, rb}, 16'd0, S_Y, 5'd0, 1'b0, 1'b0, 4'd3));
      push_r(mk(5'd25, 16'd0, S_Z, 5'd3, 1'b0, 1'b0, 4'd4));
      push_r(mk(5'd19, 16'd0, S_MAR, 5'd0, 1'b0, 1'b0, 4'd5));
      if (op == 5'd0) begin
        model_wait(d2, S_MDRMEM, S_MDRIN | S_MDRMEM, 1'b1, 1'b0, 4'd6, to);
        if (!to) push_r(mk(5'd21, oh, 10'd0, 5'd0, 1'b0, 1'b0, 4'd7));
      end else begin
        push_r(mk({1'b0, ra}, 16'd0, S_MDRIN, 5'd0, 1'b0, 1'b0, 4'd6));
        model_wait(d2, 10'd0, 10'd0, 1'b0, 1'b1, 4'd7, to);
      end
      if (to) begin
        halt_tail(1'b1, halt_len);
        halts = 1'b1;
      end
    end else begin
      case (op)
        5'd22:   push_r(mk(5'd22, oh, 10'd0, 5'd0, 1'b0, 1'b0, 4'd3));
        5'd23:   push_r(mk({1'b0, ra}, 16'd0, S_OUT, 5'd0, 1'b0, 1'b0, 4'd3));
        5'd24:   push_r(mk(5'd16, oh, 10'd0, 5'd0, 1'b0, 1'b0, 4'd3));
        5'd25:   push_r(mk(5'd17, oh, 10'd0, 5'd0, 1'b0, 1'b0, 4'd3));
        5'd27: begin
          push_r(mk(5'd31, 16'd0, 10'd0, 5'd0, 1'b0, 1'b0, 4'd3));
          halt_tail(1'b0, halt_len);
          halts = 1'b1;
        end
        default: push_r(mk(5'd31, 16'd0, 10'd0, 5'd0, 1'b0, 1'b0, 4'd3));
      endcase
    end
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic apply_stimulus(input string name, input logic [31:0] ir, input int n);
    bus.ir    = ir;
    seen_regs = 16'd0;
    seen_alu  = 5'd0;
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      bus.mem_ready = rdy_q[i];
      @(negedge clk);
      check_output($sformatf("%s[%0d]", name, i), exp_q[i]);
      seen_regs |= bus.reg_in;
      seen_alu  |= bus.alu_op;
      @(posedge clk);
      #1;
    end
    bus.mem_ready = 1'b0;
  endtask

  task automatic do_reset(input string name);
    rst_n         = 1'b0;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    check_output(name, mk(5'd31, 16'd0, 10'd0, 5'd0, 1'b0, 1'b0, 4'd0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  vec_t vecs[10];

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit          h;
    logic [4:0]  op;
    logic [31:0] ir;

    vecs[0] = '{"add",   32'h18918000, 0, 0, 16'h0002, 5'd3};
    vecs[1] = '{"ld",    32'h02280010, 3, 3, 16'h0010, 5'd3};
    vecs[2] = '{"mul",   32'h7B380000, 1, 0, 16'h0000, 5'd15};
    vecs[3] = '{"st",    32'h14900008, 0, 2, 16'h0000, 5'd3};
    vecs[4] = '{"addi",  32'h607FFFFF, 2, 0, 16'h0001, 5'd12};
    vecs[5] = '{"out",   32'hBB800000, 0, 0, 16'h0000, 5'd0};
    vecs[6] = '{"mfhi",  32'hC1800000, 0, 0, 16'h0008, 5'd0};
    vecs[7] = '{"ill31", 32'hF8000000, 0, 0, 16'h0000, 5'd0};
    vecs[8] = '{"in",    32'hB7800000, 0, 0, 16'h8000, 5'd0};
    vecs[9] = '{"ror",   32'h491A0000, 3, 0, 16'h0004, 5'd9};

    bus.ir        = 32'd0;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset("reset");

    foreach (vecs[i]) begin
      build_trace(vecs[i].ir, vecs[i].d1, vecs[i].d2, 0, h);
      apply_stimulus(vecs[i].name, vecs[i].ir, exp_q.size());
      check_value({vecs[i].name, "_regs"}, {16'd0, seen_regs}, {16'd0, vecs[i].exp_regs});
      check_value({vecs[i].name, "_alu"}, {27'd0, seen_alu}, {27'd0, vecs[i].exp_alu});
    end

    build_trace(32'h18918000, 7, 0, 20, h);
    apply_stimulus("timeout", 32'h18918000, exp_q.size());
    do_reset("timeout_reset");

    build_trace(32'hD8000000, 0, 0, 20, h);
    apply_stimulus("halt", 32'hD8000000, exp_q.size());
    do_reset("halt_reset");

    // Reset dropped between edges in the middle of a sub's T4 step.
    build_trace(32'h20918000, 0, 0, 0, h);
    apply_stimulus("sub", 32'h20918000, 4);
    bus.mem_ready = 1'b0;
    @(negedge clk);
    check_output("sub_t4", exp_q[4]);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_reset", mk(5'd31, 16'd0, 10'd0, 5'd0, 1'b0, 1'b0, 4'd0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    build_trace(32'h18918000, 0, 0, 0, h);
    apply_stimulus("after_reset", 32'h18918000, exp_q.size());

    for (int n = 0; n < 80; n++) begin
      op = 5'($urandom_range(0, 31));
      ir = {op, 27'($urandom)};
      build_trace(ir, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), 3, h);
      apply_stimulus($sformatf("rand%0d_op%0d", n, op), ir, exp_q.size());
      if (h) do_reset($sformatf("rand%0d_reset", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
